// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, runs one-outstanding fetches
// and presents each instruction with its PC to decode.
module ifu #(
   parameter int              XLEN     = 64,
   parameter int              INST_W   = 32,
   parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
   input  logic              clk_i_ifu,
   input  logic              rst_n_i_ifu,
   input  logic              jump_branch_i_ifu,
   input  logic [XLEN-1:0]   dnpc_i_ifu,
   output logic              imem_req_valid_o_ifu,
   input  logic              imem_req_ready_i_ifu,
   output logic [XLEN-1:0]   imem_addr_o_ifu,
   input  logic              imem_resp_valid_i_ifu,
   input  logic [INST_W-1:0] imem_rdata_i_ifu,
   output logic              inst_valid_o_ifu,
   input  logic              inst_ready_i_ifu,
   output logic [INST_W-1:0] inst_o_ifu,
   output logic [XLEN-1:0]   pc_o_ifu,
   output logic              misalign_o_ifu
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_HALT
   } state_t;

   state_t            state;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   pc_held;
   logic [INST_W-1:0] inst_held;
   logic              kill;
   logic              misalign;
   logic              redir;
   logic              bad_tgt;

   assign redir   = jump_branch_i_ifu;
   assign bad_tgt = dnpc_i_ifu[1:0] != 2'b00;

   always_ff @(posedge clk_i_ifu) begin
      if (!rst_n_i_ifu) begin
         state     <= S_REQ;
         pc        <= RESET_PC;
         pc_held   <= '0;
         inst_held <= '0;
         kill      <= 1'b0;
         misalign  <= 1'b0;
      end else if (redir && bad_tgt && state != S_HALT) begin
         state    <= S_HALT;
         misalign <= 1'b1;
         kill     <= 1'b0;
      end else begin
         unique case (state)
            S_REQ: begin
               if (redir) pc <= dnpc_i_ifu;
               if (imem_req_ready_i_ifu) begin
                  state <= S_WAIT;
                  // accepted at the old pc, so its data is wrong-path
                  kill  <= redir;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid_i_ifu) begin
                  kill <= 1'b0;
                  if (redir || kill) begin
                     state <= S_REQ;
                  end else begin
                     state     <= S_HOLD;
                     inst_held <= imem_rdata_i_ifu;
                     pc_held   <= pc;
                  end
               end else if (redir) begin
                  kill <= 1'b1;
               end
               if (redir) pc <= dnpc_i_ifu;
            end
            S_HOLD: begin
               if (redir) begin
                  pc    <= dnpc_i_ifu;
                  state <= S_REQ;
               end else if (inst_ready_i_ifu) begin
                  pc    <= pc + XLEN'(4);
                  state <= S_REQ;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
         endcase
      end
   end

   // valids are pure state decodes; reset low forces every output to 0
   assign imem_req_valid_o_ifu = rst_n_i_ifu && state == S_REQ;
   assign inst_valid_o_ifu     = rst_n_i_ifu && state == S_HOLD;
   assign imem_addr_o_ifu      = rst_n_i_ifu ? pc : '0;
   assign inst_o_ifu           = rst_n_i_ifu ? inst_held : '0;
   assign pc_o_ifu             = rst_n_i_ifu ? pc_held : '0;
   assign misalign_o_ifu       = rst_n_i_ifu && misalign;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed vector table, hand sequences, then random
// traffic against a transaction-level fetch model.
module tb_ifu;

   localparam logic [63:0] B  = 64'h8000_0000;
   localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n, jb, rr, rv, ir;
   logic [63:0] dnpc;
   logic [31:0] rdata;
   logic        req_valid, inst_valid, mis;
   logic [63:0] addr, pc;
   logic [31:0] inst;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifu dut (
      .clk_i_ifu             (clk),
      .rst_n_i_ifu           (rst_n),
      .jump_branch_i_ifu     (jb),
      .dnpc_i_ifu            (dnpc),
      .imem_req_valid_o_ifu  (req_valid),
      .imem_req_ready_i_ifu  (rr),
      .imem_addr_o_ifu       (addr),
      .imem_resp_valid_i_ifu (rv),
      .imem_rdata_i_ifu      (rdata),
      .inst_valid_o_ifu      (inst_valid),
      .inst_ready_i_ifu      (ir),
      .inst_o_ifu            (inst),
      .pc_o_ifu              (pc),
      .misalign_o_ifu        (mis)
   );

   typedef struct {
      logic        rst;
      logic        jb;
      logic [63:0] dnpc;
      logic        rr;
      logic        rv;
      logic [31:0] rdata;
      logic        ir;
      logic        e_rv;
      logic [63:0] e_addr;
      logic        e_iv;
      logic [31:0] e_inst;
      logic [63:0] e_pc;
      logic        e_mis;
   } vec_t;

   function automatic vec_t v(
      input logic r, input logic j, input logic [63:0] d,
      input logic q, input logic s, input logic [31:0] dat,
      input logic i, input logic erv, input logic [63:0] ea,
      input logic eiv, input logic [31:0] ei, input logic [63:0] ep,
      input logic em);
      vec_t t;
      t.rst = r;  t.jb = j;  t.dnpc = d;  t.rr = q;  t.rv = s;
      t.rdata = dat;  t.ir = i;  t.e_rv = erv;  t.e_addr = ea;
      t.e_iv = eiv;  t.e_inst = ei;  t.e_pc = ep;  t.e_mis = em;
      return t;
   endfunction

   task automatic check(input string name, input logic erv,
                        input logic [63:0] ea, input logic eiv,
                        input logic [31:0] ei, input logic [63:0] ep,
                        input logic em);
      checks++;
      if ({req_valid, addr, inst_valid, inst, pc, mis} !==
          {erv, ea, eiv, ei, ep, em}) begin
         errors++;
         $display("FAIL %s t=%0t: got rv=%b addr=%h iv=%b inst=%h pc=%h mis=%b want rv=%b addr=%h iv=%b inst=%h pc=%h mis=%b",
                  name, $time, req_valid, addr, inst_valid, inst, pc, mis,
                  erv, ea, eiv, ei, ep, em);
      end
   endtask

   task automatic apply(input vec_t t, input string name);
      rst_n = t.rst;  jb = t.jb;  dnpc = t.dnpc;  rr = t.rr;
      rv = t.rv;  rdata = t.rdata;  ir = t.ir;
      @(posedge clk);
      #1;
      check(name, t.e_rv, t.e_addr, t.e_iv, t.e_inst, t.e_pc, t.e_mis);
   endtask

   vec_t tbl[$];

   // reference model state
   logic [63:0] m_pc, m_hpc, paddr;
   logic [31:0] m_hinst;
   bit          m_out, m_stale, m_hold, m_halt;
   bit          pend, req_now, acc, bad;
   int          dly, hcnt, r;

   initial begin
      rst_n = 1'b0;  jb = 1'b0;  dnpc = '0;  rr = 1'b0;
      rv = 1'b0;  rdata = '0;  ir = 1'b0;

      //          rst jb dnpc       rr rv rdata ir  rv addr       iv inst pc        mis
      tbl.push_back(v(0, 0, 0,        0, 0, 0,    0,  0, 0,         0, 0,    0,        0));
      tbl.push_back(v(0, 0, 0,        1, 1, 9,    1,  0, 0,         0, 0,    0,        0));
      tbl.push_back(v(1, 0, 0,        0, 0, 0,    0,  1, B,         0, 0,    0,        0));
      tbl.push_back(v(1, 0, 0,        1, 0, 0,    0,  0, B,         0, 0,    0,        0));
      tbl.push_back(v(1, 0, 0,        0, 1, 'h11, 0,  0, B,         1, 'h11, B,        0));
      tbl.push_back(v(1, 0, 0,        1, 0, 0,    1,  1, B+4,       0, 'h11, B,        0));
      tbl.push_back(v(1, 0, 0,        1, 0, 0,    0,  0, B+4,       0, 'h11, B,        0));
      tbl.push_back(v(1, 0, 0,        0, 1, 'h22, 0,  0, B+4,       1, 'h22, B+4,      0));
      tbl.push_back(v(1, 0, 0,        1, 0, 0,    0,  0, B+4,       1, 'h22, B+4,      0));
      tbl.push_back(v(1, 0, 0,        1, 1, 'h99, 0,  0, B+4,       1, 'h22, B+4,      0));
      tbl.push_back(v(1, 1, B+'h40,   0, 0, 0,    1,  1, B+'h40,    0, 'h22, B+4,      0));
      tbl.push_back(v(1, 0, 0,        1, 0, 0,    0,  0, B+'h40,    0, 'h22, B+4,      0));
      tbl.push_back(v(1, 1, B+'h100,  0, 0, 0,    0,  0, B+'h100,   0, 'h22, B+4,      0));
      tbl.push_back(v(1, 0, 0,        0, 0, 0,    0,  0, B+'h100,   0, 'h22, B+4,      0));
      tbl.push_back(v(1, 0, 0,        0, 1, 'h33, 0,  1, B+'h100,   0, 'h22, B+4,      0));
      tbl.push_back(v(1, 0, 0,        1, 0, 0,    0,  0, B+'h100,   0, 'h22, B+4,      0));
      tbl.push_back(v(1, 0, 0,        0, 1, 'h44, 0,  0, B+'h100,   1, 'h44, B+'h100,  0));
      tbl.push_back(v(1, 1, B+'h42,   1, 0, 0,    0,  0, B+'h100,   0, 'h44, B+'h100,  1));
      tbl.push_back(v(1, 1, B,        1, 1, 'h55, 1,  0, B+'h100,   0, 'h44, B+'h100,  1));
      tbl.push_back(v(0, 0, 0,        0, 0, 0,    0,  0, 0,         0, 0,    0,        0));
      tbl.push_back(v(1, 0, 0,        0, 0, 0,    0,  1, B,         0, 0,    0,        0));

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // wrap at the top of the address space, then reset mid-WAIT
      apply(v(1, 1, TOP, 0, 0, 0, 0,  1, TOP, 0, 0, 0, 0), "wrap_redir");
      apply(v(1, 0, 0,   1, 0, 0, 0,  0, TOP, 0, 0, 0, 0), "wrap_acc");
      apply(v(1, 0, 0,   0, 1, 'h77, 0,  0, TOP, 1, 'h77, TOP, 0), "wrap_hold");
      apply(v(1, 0, 0,   0, 0, 0, 1,  1, 0, 0, 'h77, TOP, 0), "wrap_zero");
      apply(v(1, 0, 0,   1, 0, 0, 0,  0, 0, 0, 'h77, TOP, 0), "wait0");
      apply(v(0, 0, 0,   0, 1, 'h88, 0,  0, 0, 0, 0, 0, 0), "rst_in_wait");
      apply(v(1, 0, 0,   1, 0, 0, 0,  0, B, 0, 0, 0, 0), "restart_acc");
      apply(v(1, 0, 0,   0, 1, 'h66, 0,  0, B, 1, 'h66, B, 0), "restart_hold");

      // random traffic
      m_pc = B;  m_hpc = '0;  m_hinst = '0;  paddr = '0;
      m_out = 0;  m_stale = 0;  m_hold = 0;  m_halt = 0;
      pend = 0;  dly = 0;  hcnt = 0;
      for (int c = 0; c < 4000; c++) begin
         rst_n = !(c < 2 || $urandom_range(0, 299) == 0 || hcnt >= 4);
         rr = $urandom_range(0, 3) != 0;
         ir = $urandom_range(0, 2) != 0;
         jb = $urandom_range(0, 7) == 0;
         r  = int'($urandom_range(0, 31));
         if (!jb) dnpc = {$urandom, $urandom};
         else if (r == 0) dnpc = B + 64'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
         else if (r == 1) dnpc = 64'hFFFF_FFFF_FFFF_FFF8;
         else dnpc = B + 64'(4 * $urandom_range(0, 63));
         rv = (pend && dly == 0) || (!pend && $urandom_range(0, 9) == 0);
         rdata = pend ? (paddr[31:0] ^ 32'h1357_9BDF) : $urandom;
         @(posedge clk);
         bad = jb && dnpc[1:0] != 2'b00;
         if (!rst_n) begin
            m_pc = B;  m_hpc = '0;  m_hinst = '0;
            m_out = 0;  m_stale = 0;  m_hold = 0;  m_halt = 0;
            pend = 0;  hcnt = 0;
         end else begin
            req_now = !m_halt && !m_out && !m_hold;
            acc = req_now && rr && !bad;
            if (acc) begin
               pend = 1;  dly = int'($urandom_range(0, 2));  paddr = m_pc;
            end else if (pend && rv) pend = 0;
            else if (pend && dly > 0) dly--;
            if (m_halt) hcnt++;
            else if (bad) begin
               m_halt = 1;  m_out = 0;  m_hold = 0;  m_stale = 0;
            end else if (jb) begin
               if (req_now) begin
                  if (rr) begin m_out = 1;  m_stale = 1; end
               end else if (m_out) begin
                  if (rv) begin m_out = 0;  m_stale = 0; end
                  else m_stale = 1;
               end else m_hold = 0;
               m_pc = dnpc;
            end else if (acc) m_out = 1;
            else if (m_out && rv) begin
               m_out = 0;
               if (m_stale) m_stale = 0;
               else begin m_hold = 1;  m_hinst = rdata;  m_hpc = m_pc; end
            end else if (m_hold && ir) begin
               m_hold = 0;  m_pc = m_pc + 64'd4;
            end
         end
         #1;
         if (!rst_n) check("rand_rst", 0, 0, 0, 0, 0, 0);
         else check("rand", !m_halt && !m_out && !m_hold, m_pc, m_hold,
                    m_hinst, m_hpc, m_halt);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit: owns the architectural PC, issues one-outstanding fetches to instruction memory and hands each fetched instruction plus its PC to decode over a valid/ready handshake.
- Sits directly upstream of decode/execute. Consumes the branch compare unit's redirect outputs `jump_branch` and `dnpc` to steer the PC.
- Discards wrong-path fetches.
- Detects misaligned redirect targets and halts.

Parameters:
- XLEN, 64, width of PC and addresses (matches `RegBus`).
- INST_W, 32, instruction width.
- RESET_PC, 64'h8000_0000, PC value after reset.

Ports:
- clk_i_ifu  input  1  clock, all state updates on rising edge.
- rst_n_i_ifu  input  1  synchronous active-low reset.
- jump_branch_i_ifu  input  1  redirect request from branch compare unit, sampled every cycle.
- dnpc_i_ifu  input  XLEN  redirect target, valid when jump_branch_i_ifu=1.
- imem_req_valid_o_ifu  output  1  fetch request valid.
- imem_req_ready_i_ifu  input  1  memory accepts request.
- imem_addr_o_ifu  output  XLEN  fetch address (= PC register).
- imem_resp_valid_i_ifu  input  1  fetch data valid (exactly one per accepted request).
- imem_rdata_i_ifu  input  INST_W  fetch data.
- inst_valid_o_ifu  output  1  instruction valid to decode.
- inst_ready_i_ifu  input  1  decode accepts instruction.
- inst_o_ifu  output  INST_W  held instruction.
- pc_o_ifu  output  XLEN  PC of held instruction.
- misalign_o_ifu  output  1  sticky: redirect target not 4-byte aligned.

Behaviour:
- Reset (rst_n_i_ifu=0 at a clock edge) takes priority over all other inputs, in any state and mid-transaction:
  - pc = RESET_PC, state = REQ, kill = 0, misalign = 0, inst/pc_o registers = 0.
  - While rst_n is low, all outputs are forced to 0.
  - Any response belonging to a pre-reset request is outside the contract; memory is reset together with the IFU.
- States: REQ, WAIT, HOLD, HALT.
- REQ:
  - Outputs: imem_req_valid=1, addr=pc.
  - On req_ready: go to WAIT.
- WAIT:
  - Outputs: req_valid=0.
  - On resp_valid with kill=1: drop the data, clear kill, go to REQ.
  - On resp_valid with kill=0: latch rdata into inst_o and pc into pc_o, go to HOLD.
- HOLD:
  - Outputs: inst_valid=1; inst_o and pc_o stable until the handshake.
  - On inst_ready: pc <= pc+4 (mod 2^XLEN, wraps silently), go to REQ.
- HALT:
  - All valids 0; misalign=1.
  - Exited only by reset.
- Redirect (jump_branch=1) is evaluated before normal transitions:
  - If dnpc[1:0] != 0: go to HALT, set misalign, clear kill, pc unchanged.
  - REQ, req_ready=0: pc <= dnpc, stay REQ. The address changes next cycle; memory must tolerate this because the request was not accepted.
  - REQ, req_ready=1: request is accepted at the old pc; pc <= dnpc, kill <= 1, go to WAIT.
  - WAIT, resp_valid=0: pc <= dnpc, kill <= 1.
  - WAIT, resp_valid=1: drop the data, pc <= dnpc, kill <= 0, go to REQ.
  - HOLD: held instruction is invalidated (whether or not inst_ready=1 that cycle), pc <= dnpc, go to REQ. Redirect target overrides pc+4.
  - HALT: ignored.
- Latency:
  - Minimum 3 cycles from entering REQ to inst_valid: REQ (accepted), WAIT (resp same cycle), HOLD.
  - Back-to-back throughput is one instruction per 3 cycles.
  - Redirect to next request issue: 1 cycle.
- At most one outstanding request; req_valid is never asserted in WAIT.
- imem_resp_valid outside WAIT is a protocol violation and is ignored.
- No combinational path from any input to req_valid or inst_valid. These are pure state decodes (plus rst_n forcing).

Test Plan:
- Reset release, imem ready=1, resp 1 cycle after accept, decode ready=1 -> addresses 0x8000_0000, 0x8000_0004, 0x8000_0008; pc_o matches each address; inst_valid one cycle every 3.
- Decode ready held 0 for 5 cycles in HOLD -> inst_o and pc_o stable, no new req_valid; after ready=1, next addr is pc+4.
- Redirect dnpc=0x8000_0100 in WAIT with resp delayed 2 cycles -> stale response dropped (inst_valid stays 0), next addr 0x8000_0100, kill cleared.
- Redirect in HOLD simultaneous with inst_ready=1, dnpc=0x8000_0040 -> next addr 0x8000_0040, not pc+4.
- Redirect dnpc=0x8000_0042 -> misalign_o=1, HALT, no further requests; apply reset -> misalign=0, fetch restarts at 0x8000_0000.
- pc=0xFFFF_FFFF_FFFF_FFFC accepted -> next addr 0x0 (wrap); reset asserted in WAIT -> all outputs 0, restart clean.
